// File: rtl/fim_cross_arb_pkg.sv
// Shared types and helpers for the handshake-CDC arbiter: FSM state encoding
// and the round-robin search used by fim_rr_arb.
package fim_cross_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } arb_state_e;

    localparam int MAX_REQ = 16;

    // First set bit of req at or after last+1, wrapping modulo n; 0 when none is set.
    function automatic logic [3:0] rr_next(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         last,
                                           input int                 n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(last) + k) % n;
            if ((k <= n) && !found && req[idx]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fim_cross_handshake_arb_rr.sv
// Combinational round-robin grant: request vector plus last grant in,
// one-hot grant and its index out. The parent owns the pointer register.
module fim_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_req
);
    import fim_cross_arb_pkg::*;

    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         last_ext;
    logic [3:0]         pick;

    assign req_ext  = MAX_REQ'(req);
    assign last_ext = 4'(last);

    always_comb begin
        pick      = rr_next(req_ext, last_ext, NUM_REQ);
        grant_idx = IDW'(pick);
        any_req   = |req;
        grant     = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/fim_cross_handshake_arb.sv
// Source-domain sequencer sharing one handshake CDC channel among NUM_REQ
// requesters: round-robin grant, single-cycle launch, wait for ack, ack back.
module fim_cross_handshake_arb #(
    parameter  int NUM_REQ        = 4,
    parameter  int WIDTH          = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [IDW+WIDTH-1:0]          xfer_data,
    output logic                          xfer_valid,
    input  logic                          xfer_ack,
    output logic                          busy,
    output logic                          err_timeout,
    output logic                          err_spurious,
    input  logic                          err_clr,
    output logic [31:0]                   xfer_cnt
);
    import fim_cross_arb_pkg::*;

    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TLIM   = TMO_EN ? TIMEOUT_CYCLES : 1;
    localparam int TW     = $clog2(TLIM + 1);

    arb_state_e          state, state_nxt;
    logic [IDW-1:0]      last_grant;
    logic [NUM_REQ-1:0]  req_eligible;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDW-1:0]      arb_idx;
    logic                arb_any;
    logic [TW-1:0]       tcnt;
    logic                grant_load;
    logic                ack_done;
    logic                tmo_hit;
    logic                spurious_hit;

    // A requester still holds req_valid during its req_ack cycle; masking it
    // keeps a lone requester from being granted a second, duplicate transfer.
    assign req_eligible = req_valid & ~req_ack;

    fim_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req       (req_eligible),
        .last      (last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        xfer_valid   = 1'b0;
        busy         = 1'b0;
        grant_load   = 1'b0;
        ack_done     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_load = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                xfer_valid = 1'b1;
                busy       = 1'b1;
                state_nxt  = WAIT_ACK;
            end
            WAIT_ACK: begin
                busy = 1'b1;
                if (xfer_ack) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        tmo_hit      = TMO_EN && (state == WAIT_ACK) && !xfer_ack && (tcnt == TW'(TLIM - 1));
        spurious_hit = xfer_ack && (state != WAIT_ACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(NUM_REQ - 1);
            xfer_data  <= '0;
        end else if (grant_load) begin
            last_grant <= arb_idx;
            xfer_data  <= {arb_idx, req_data[arb_idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ack  <= '0;
            xfer_cnt <= '0;
        end else begin
            req_ack <= '0;
            if (ack_done) begin
                req_ack  <= NUM_REQ'(1) << last_grant;
                xfer_cnt <= xfer_cnt + 32'd1;
            end
        end
    end

    // The transfer cannot be aborted once launched, so a timeout only flags
    // the error; the counter saturates and keeps waiting for the late ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt         <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if ((state != WAIT_ACK) || xfer_ack) tcnt <= '0;
            else if (tcnt != TW'(TLIM))          tcnt <= tcnt + 1'b1;

            if (tmo_hit)      err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;

            if (spurious_hit) err_spurious <= 1'b1;
            else if (err_clr) err_spurious <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fim_cross_handshake_arb.sv
// Directed bench for fim_cross_handshake_arb: launch/ack latency, round-robin
// order, timeout, spurious ack, error clear and reset in the middle of a transfer.
module tb_fim_cross_handshake_arb;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int TMO     = 16;
    localparam int IDW     = 2;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [IDW+WIDTH-1:0]          xfer_data;
    logic                          xfer_valid;
    logic                          xfer_ack;
    logic                          busy;
    logic                          err_timeout;
    logic                          err_spurious;
    logic                          err_clr;
    logic [31:0]                   xfer_cnt;

    int checks = 0;
    int errors = 0;

    fim_cross_handshake_arb #(
        .NUM_REQ        (NUM_REQ),
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .xfer_data    (xfer_data),
        .xfer_valid   (xfer_valid),
        .xfer_ack     (xfer_ack),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious),
        .err_clr      (err_clr),
        .xfer_cnt     (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs for the current cycle, then move to the next cycle's sample point.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic ack, input logic clr);
        req_valid = valid;
        xfer_ack  = ack;
        err_clr   = clr;
        @(negedge clk);
    endtask

    initial begin
        int          rr_order [5];
        logic [33:0] exp_d;
        logic [1:0]  gid;
        rr_order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        xfer_ack  = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_busy",       64'(busy),         64'd0);
        checkOutput("rst_xfer_valid", 64'(xfer_valid),   64'd0);
        checkOutput("rst_req_ack",    64'(req_ack),      64'd0);
        checkOutput("rst_xfer_data",  64'(xfer_data),    64'd0);
        checkOutput("rst_xfer_cnt",   64'(xfer_cnt),     64'd0);
        checkOutput("rst_err_tmo",    64'(err_timeout),  64'd0);
        checkOutput("rst_err_spur",   64'(err_spurious), 64'd0);

        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        // Single request on index 2, ack at cycle 5
        req_data[2] = 32'hDEAD_BEEF;
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("single_launch",   64'(xfer_valid), 64'd1);
        checkOutput("single_data",     64'(xfer_data),  64'h2_DEAD_BEEF);
        checkOutput("single_busy",     64'(busy),       64'd1);
        checkOutput("single_no_ack",   64'(req_ack),    64'd0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("single_pulse_1cy", 64'(xfer_valid), 64'd0);
        checkOutput("single_wait_busy", 64'(busy),       64'd1);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_req_ack",  64'(req_ack),    64'h4);
        checkOutput("single_cnt",      64'(xfer_cnt),   64'd1);
        checkOutput("single_idle",     64'(busy),       64'd0);
        checkOutput("single_ack_nolaunch", 64'(xfer_valid), 64'd0);
        checkOutput("single_data_held", 64'(xfer_data), 64'h2_DEAD_BEEF);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("single_no_regrant", 64'(busy),    64'd0);
        checkOutput("single_ack_1cy",    64'(req_ack), 64'd0);

        // Ack while idle is spurious; set beats a same-cycle clear
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("spur_flag",   64'(err_spurious), 64'd1);
        checkOutput("spur_no_ack", 64'(req_ack),      64'd0);
        checkOutput("spur_cnt",    64'(xfer_cnt),     64'd1);
        checkOutput("spur_idle",   64'(busy),         64'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("spur_set_wins", 64'(err_spurious), 64'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("spur_cleared",  64'(err_spurious), 64'd0);

        // Withheld ack: requester 1 drops req_valid after grant, timeout at 16
        req_data[1] = 32'h1111_1111;
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("tmo_launch", 64'(xfer_valid), 64'd1);
        checkOutput("tmo_data",   64'(xfer_data),  64'h1_1111_1111);
        for (int k = 1; k <= TMO; k++) applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("tmo_before",  64'(err_timeout), 64'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("tmo_set",     64'(err_timeout), 64'd1);
        checkOutput("tmo_busy",    64'(busy),        64'd1);
        checkOutput("tmo_nolaunch", 64'(xfer_valid), 64'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("tmo_late_ack", 64'(req_ack),      64'h2);
        checkOutput("tmo_cnt",      64'(xfer_cnt),     64'd2);
        checkOutput("tmo_sticky",   64'(err_timeout),  64'd1);
        checkOutput("tmo_not_spur", 64'(err_spurious), 64'd0);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("tmo_cleared",  64'(err_timeout),  64'd0);

        // Reset during WAIT_ACK with everyone requesting
        for (int i = 0; i < NUM_REQ; i++) req_data[i] = 32'hA000_0000 + 32'(i);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("mid_grant_id", 64'(xfer_data[33:32]), 64'd2);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("mid_wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",  64'(busy),       64'd0);
        checkOutput("mid_rst_data",  64'(xfer_data),  64'd0);
        checkOutput("mid_rst_cnt",   64'(xfer_cnt),   64'd0);
        checkOutput("mid_rst_valid", 64'(xfer_valid), 64'd0);
        checkOutput("mid_rst_ack",   64'(req_ack),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous requests after reset: grants 0,1,2,3,0 back to back
        applyStimulus(4'b1111, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            gid   = 2'(rr_order[n]);
            exp_d = {gid, 32'hA000_0000 + 32'(gid)};
            checkOutput($sformatf("rr%0d_launch", n), 64'(xfer_valid), 64'd1);
            checkOutput($sformatf("rr%0d_data", n),   64'(xfer_data),  64'(exp_d));
            applyStimulus(4'b1111, 1'b0, 1'b0);
            checkOutput($sformatf("rr%0d_wait", n),   64'(xfer_valid), 64'd0);
            checkOutput($sformatf("rr%0d_noack", n),  64'(req_ack),    64'd0);
            applyStimulus(4'b1111, 1'b1, 1'b0);
            checkOutput($sformatf("rr%0d_req_ack", n), 64'(req_ack),   64'(4'b0001 << gid));
            checkOutput($sformatf("rr%0d_excl", n),   64'(xfer_valid), 64'd0);
            applyStimulus(4'b1111, 1'b0, 1'b0);
        end
        checkOutput("rr_cnt", 64'(xfer_cnt), 64'd5);
        applyStimulus(4'b0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
